logic_unit_seq: RTL and testbench
=================================

LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter LANE, default 4, meaning the bits processed per cycle; WIDTH SHALL be an integer multiple of LANE, and LANE SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port x, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port y, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port op, input, 3 bits: the operation select.
REQ-010 The block SHALL have port o, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: o and the flags are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port zero, output, 1 bit: o is all zeros.
REQ-014 The block SHALL have port ones, output, 1 bit: o is all ones.

Function
REQ-015 The op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (x & ~y), 7 PASS (o = x).
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in BUSY and DONE, in_ready SHALL be 0.
REQ-018 On a clock edge with in_valid=1 and in_ready=1, the block SHALL capture x, y and op into internal registers, clear the lane counter cnt, and move to BUSY.
REQ-019 In BUSY, each cycle SHALL compute bits [cnt*LANE +: LANE] from the captured operands, write them into the result register, and increment cnt.
REQ-020 When cnt = WIDTH/LANE-1 in BUSY, the next edge SHALL write the final lane, move to DONE, and assert out_valid.
REQ-021 Latency SHALL be WIDTH/LANE cycles: if accepted at edge k, out_valid SHALL be 1 after edge k+WIDTH/LANE (4 cycles at the defaults).
REQ-022 Bits of o not yet written in the current operation SHALL read as 0, because the result register is cleared on accept.
REQ-023 zero and ones SHALL be derived from the complete result and SHALL be valid whenever out_valid=1; both SHALL be 0 when out_valid=0.
REQ-024 In DONE, o, zero, ones and out_valid SHALL hold stable until out_ready=1.
REQ-025 On an edge in DONE with out_ready=1, the block SHALL return to IDLE and deassert out_valid; o SHALL keep its last value.
REQ-026 A new request SHALL NOT be accepted in the same cycle as result hand-off; the earliest next accept is the cycle after returning to IDLE.
REQ-027 Changes on x, y, op or in_valid during BUSY or DONE SHALL have no effect on the result in progress.
REQ-028 out_ready asserted outside DONE SHALL be ignored.
REQ-029 When LANE = WIDTH, the block SHALL spend exactly one cycle in BUSY.
REQ-030 The lane counter SHALL be ceil(log2(WIDTH/LANE)) bits wide, minimum 1, and SHALL never wrap within an operation.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without a clock edge, force state to IDLE, cnt to 0, o to 0, out_valid to 0, zero to 0 and ones to 0.
REQ-032 While rst_n=0, in_ready SHALL be 0; it SHALL become 1 on the first cycle after rst_n returns to 1.
REQ-033 Reset asserted during BUSY or DONE SHALL abort the operation and discard the partial result; no out_valid pulse SHALL follow.

Verification (WIDTH=16, LANE=4 unless stated)
REQ-034 The bench SHALL cover: op=1 (OR), x=0xF0F0, y=0x0F0F -> out_valid exactly 4 cycles after accept, o=0xFFFF, ones=1, zero=0.
REQ-035 The bench SHALL cover: op=0 (AND), x=0xF0F0, y=0x0F0F -> o=0x0000, zero=1, ones=0.
REQ-036 The bench SHALL cover: op=6 (ANDN), x=0xFFFF, y=0x0F0F, with out_ready held 0 for 3 cycles -> o=0xF0F0 stable and out_valid=1 throughout, then return to IDLE one edge after out_ready=1.
REQ-037 The bench SHALL cover: accept op=2 (XOR), x=0x1234, y=0xFFFF, then change x and y every cycle during BUSY -> o=0xEDCB.
REQ-038 The bench SHALL cover: rst_n pulsed low for 1 cycle after 2 BUSY cycles -> o=0 and out_valid=0 immediately, no out_valid pulse, in_ready=1 after release.
REQ-039 The bench SHALL cover: WIDTH=8, LANE=8, op=4 (NOR), x=0x00, y=0x00 -> o=0xFF after 1 cycle, ones=1; repeated for all 8 op codes against a reference model.

Source files
------------

// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - lane-serial bitwise logic unit with valid/ready handshakes
module logic_unit_seq #(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] o,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             zero,
   output logic             ones
);

   localparam int NLANES = WIDTH / LANE;
   localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;

   if (LANE < 1 || (WIDTH % LANE) != 0) begin : g_bad_params
      $error("logic_unit_seq: WIDTH must be a non-zero multiple of LANE");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] yr;
   logic [2:0]       opr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] o_reg;
   logic             last;

   assign last = (cnt == CW'(NLANES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Full-width result of the captured operands; only the current lane is stored.
   always_comb begin
      res = '0;
      case (opr)
         3'd0: res = xr & yr;
         3'd1: res = xr | yr;
         3'd2: res = xr ^ yr;
         3'd3: res = ~(xr & yr);
         3'd4: res = ~(xr | yr);
         3'd5: res = ~(xr ^ yr);
         3'd6: res = xr & ~yr;
         3'd7: res = xr;
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr    <= '0;
         yr    <= '0;
         opr   <= '0;
         cnt   <= '0;
         o_reg <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            xr    <= x;
            yr    <= y;
            opr   <= op;
            cnt   <= '0;
            o_reg <= '0;
         end else if (state == BUSY) begin
            o_reg[cnt*LANE +: LANE] <= res[cnt*LANE +: LANE];
            if (!last) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready  = rst_n && (state == IDLE);
      out_valid = (state == DONE);
      zero      = out_valid && (o_reg == '0);
      ones      = out_valid && (&o_reg);
      o         = o_reg;
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - directed table-driven bench for logic_unit_seq
module tb_logic_unit_seq;

   logic        clk;
   logic        rst_n;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, ones16;
   logic [15:0] x16, y16, o16;
   logic [2:0]  op16;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, ones8;
   logic [7:0]  x8, y8, o8;
   logic [2:0]  op8;

   int errors = 0;
   int checks = 0;

   logic_unit_seq #(.WIDTH(16), .LANE(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .x(x16), .y(y16), .op(op16), .o(o16), .out_valid(out_valid16),
      .out_ready(out_ready16), .zero(zero16), .ones(ones16)
   );

   logic_unit_seq #(.WIDTH(8), .LANE(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .op(op8), .o(o8), .out_valid(out_valid8),
      .out_ready(out_ready8), .zero(zero8), .ones(ones8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] eo;
      logic        ez;
      logic        e1;
   } vec16_t;

   vec16_t tbl[8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return ~(a ^ b);
         3'd6: return a & ~b;
         default: return a;
      endcase
   endfunction

   // Accept, wait for out_valid (bounded), check latency/result, then hand off.
   task automatic run16(input vec16_t v, input int idx);
      int lat;
      chk($sformatf("v%0d in_ready", idx), in_ready16, 1);
      x16 = v.a; y16 = v.b; op16 = v.op; in_valid16 = 1'b1; out_ready16 = 1'b0;
      tick();
      in_valid16 = 1'b0;
      chk($sformatf("v%0d o cleared on accept", idx), o16, 0);
      lat = 0;
      while (!out_valid16 && lat < 20) begin
         tick();
         lat++;
      end
      chk($sformatf("v%0d latency", idx), lat, 4);
      chk($sformatf("v%0d o", idx), o16, v.eo);
      chk($sformatf("v%0d zero", idx), zero16, v.ez);
      chk($sformatf("v%0d ones", idx), ones16, v.e1);
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      chk($sformatf("v%0d out_valid after handoff", idx), out_valid16, 0);
      chk($sformatf("v%0d o kept", idx), o16, v.eo);
   endtask

   task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input string name);
      int lat;
      x8 = a; y8 = b; op8 = f; in_valid8 = 1'b1; out_ready8 = 1'b0;
      tick();
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 10) begin
         tick();
         lat++;
      end
      chk({name, " latency"}, lat, 1);
      chk({name, " o"}, o8, eo);
      chk({name, " zero"}, zero8, (eo == 8'h00));
      chk({name, " ones"}, ones8, (eo == 8'hFF));
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      chk({name, " in_ready after handoff"}, in_ready8, 1);
   endtask

   initial begin
      int lat;
      logic seen;

      tbl[0] = '{3'd1, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1};
      tbl[1] = '{3'd0, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{3'd2, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0};
      tbl[3] = '{3'd3, 16'hFF00, 16'h0FF0, 16'hF0FF, 1'b0, 1'b0};
      tbl[4] = '{3'd4, 16'h1234, 16'h4321, 16'hACCA, 1'b0, 1'b0};
      tbl[5] = '{3'd5, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{3'd6, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0};
      tbl[7] = '{3'd7, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0, 1'b0};

      rst_n = 1'b0;
      in_valid16 = 0; out_ready16 = 0; x16 = 0; y16 = 0; op16 = 0;
      in_valid8 = 0;  out_ready8 = 0;  x8 = 0;  y8 = 0;  op8 = 0;
      repeat (2) tick();
      chk("reset in_ready", in_ready16, 0);
      chk("reset out_valid", out_valid16, 0);
      chk("reset o", o16, 0);
      chk("reset zero", zero16, 0);
      chk("reset ones", ones16, 0);
      chk("reset in_ready w8", in_ready8, 0);
      rst_n = 1'b1;
      tick();
      chk("in_ready after release", in_ready16, 1);

      for (int i = 0; i < 8; i++) begin
         run16(tbl[i], i);
         tick();
      end

      // ANDN with result held back for 3 cycles
      x16 = 16'hFFFF; y16 = 16'h0F0F; op16 = 3'd6; in_valid16 = 1'b1; out_ready16 = 1'b0;
      tick();
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 20) begin
         tick();
         lat++;
      end
      chk("andn latency", lat, 4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("andn stall%0d o", i), o16, 16'hF0F0);
         chk($sformatf("andn stall%0d out_valid", i), out_valid16, 1);
      end
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      chk("andn out_valid after release", out_valid16, 0);
      chk("andn in_ready after release", in_ready16, 1);
      chk("andn o kept", o16, 16'hF0F0);
      tick();

      // XOR with operands scrambled during BUSY and out_ready asserted early
      x16 = 16'h1234; y16 = 16'hFFFF; op16 = 3'd2; in_valid16 = 1'b1; out_ready16 = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         x16 = 16'($urandom); y16 = 16'($urandom); op16 = 3'($urandom);
         tick();
         if (i == 0) chk("xor partial lane0", o16, 16'h000B);
         if (i == 1) chk("xor partial lane1", o16, 16'h00CB);
         if (i == 2) chk("xor partial lane2", o16, 16'h0DCB);
      end
      in_valid16 = 1'b0;
      chk("xor out_valid", out_valid16, 1);
      chk("xor o", o16, 16'hEDCB);
      tick();
      out_ready16 = 1'b0;
      chk("xor handoff out_valid", out_valid16, 0);
      chk("xor handoff in_ready", in_ready16, 1);
      tick();

      // Reset pulse after two BUSY cycles
      x16 = 16'hF0F0; y16 = 16'h0F0F; op16 = 3'd1; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      tick();
      tick();
      chk("rst partial o", o16, 16'h00FF);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async o", o16, 0);
      chk("rst async out_valid", out_valid16, 0);
      chk("rst async in_ready", in_ready16, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst in_ready after release", in_ready16, 1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid16) seen = 1'b1;
      end
      chk("rst no out_valid pulse", seen, 0);

      run8(3'd4, 8'h00, 8'h00, 8'hFF, "w8 nor zeros");
      for (int f = 0; f < 8; f++) begin
         run8(3'(f), 8'h00, 8'h00, ref8(3'(f), 8'h00, 8'h00), $sformatf("w8 op%0d 00/00", f));
         run8(3'(f), 8'hC5, 8'h3A, ref8(3'(f), 8'hC5, 8'h3A), $sformatf("w8 op%0d C5/3A", f));
         run8(3'(f), 8'h96, 8'hF0, ref8(3'(f), 8'h96, 8'hF0), $sformatf("w8 op%0d 96/F0", f));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
